// File: rtl/seq_scan_ctrl_pkg.sv
// rtl/seq_scan_ctrl_pkg.sv - shared state encodings for the word-to-serial 10010 scan controller
package seq_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        DET_A = 3'b000,
        DET_B = 3'b001,
        DET_C = 3'b010,
        DET_D = 3'b011,
        DET_E = 3'b100
    } det_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/seq_scan_ctrl_det.sv
// rtl/seq_scan_ctrl_det.sv - Mealy detector for serial pattern 10010, overlapping matches
module pattern_det_10010
    import seq_scan_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic j,
    output logic w
);

    det_state_t state;
    det_state_t next;

    // State is the longest seen suffix that is a prefix of 10010; unused codes fall back to A.
    always_comb begin
        next = DET_A;
        w    = 1'b0;
        case (state)
            DET_A: next = j ? DET_B : DET_A;
            DET_B: next = j ? DET_B : DET_C;
            DET_C: next = j ? DET_B : DET_D;
            DET_D: next = j ? DET_E : DET_A;
            DET_E: begin
                next = j ? DET_B : DET_C;
                w    = ~j;
            end
            default: next = DET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DET_A;
        end else if (clr) begin
            state <= DET_A;
        end else if (en) begin
            state <= next;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - loads a word on start and shifts it MSB-first through the 10010 detector
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             bit_out,
    output logic             match,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    ctrl_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             shifting;
    logic             accept;
    logic             det_w;

    assign shifting = (state == ST_SHIFT);
    assign accept   = (state == ST_IDLE) && start;
    assign bit_out  = shifting & sreg[WIDTH-1];
    assign match    = shifting & det_w;

    // cont=1 keeps detector history so a pattern may straddle two words.
    pattern_det_10010 u_det (
        .clk (clk),
        .rst (rst),
        .en  (shifting),
        .clr (accept & ~cont),
        .j   (bit_out),
        .w   (det_w)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg        <= data_in;
                        bit_cnt     <= '0;
                        match_count <= '0;
                        busy        <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg    <= {sreg[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (match && match_count != CNT_MAX) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - table vectors, corner sequences and random scans against a window model
module tb_seq_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cont;
    logic [15:0] data_in;
    logic        busy;
    logic        bit_out;
    logic        match;
    logic        done;
    logic [4:0]  match_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a match is the last five stream bits reading 10010 since the last clear.
    logic [4:0] hist;
    int         hlen;
    int         mcnt;

    typedef struct {
        logic [15:0] data;
        logic        cont;
        logic        inj;
        logic [15:0] mask;
        int          count;
    } vec_t;

    vec_t vt[7];

    seq_scan_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .data_in     (data_in),
        .busy        (busy),
        .bit_out     (bit_out),
        .match       (match),
        .done        (done),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic scan(input logic [15:0] d, input logic c, input logic inj,
                        output logic [15:0] mask, output int cnt);
        logic exp_m;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        cont    = c;
        if (!c) hlen = 0;
        mcnt = 0;
        mask = '0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (inj && i == 2) begin
                start   = 1'b1;
                data_in = ~d;
                cont    = ~c;
            end else begin
                start = 1'b0;
            end
            hist = {hist[3:0], d[15-i]};
            if (hlen < 5) hlen++;
            exp_m = (hlen >= 5) && (hist == 5'b10010);
            if (exp_m && mcnt < 31) mcnt++;
            chk($sformatf("busy_c%0d", i + 1), busy, 1'b1);
            chk($sformatf("bit_c%0d", i + 1), bit_out, d[15-i]);
            chk($sformatf("match_c%0d", i + 1), match, exp_m);
            chk($sformatf("done_c%0d", i + 1), done, 1'b0);
            mask[i] = match;
            @(negedge clk);
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b1);
        chk("match_done", match, 1'b0);
        chk("count_done", match_count, 5'(mcnt));
        if (inj) begin
            start   = 1'b1;
            data_in = ~d;
            cont    = ~c;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_after", done, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("count_hold", match_count, 5'(mcnt));
        cnt = match_count;
    endtask

    initial begin
        logic [15:0] m;
        int          cnt;

        vt[0] = '{16'h9000, 1'b0, 1'b0, 16'h0010, 1};
        vt[1] = '{16'h9248, 1'b0, 1'b0, 16'h2490, 4};
        vt[2] = '{16'h0009, 1'b0, 1'b0, 16'h0000, 0};
        vt[3] = '{16'h0000, 1'b1, 1'b0, 16'h0001, 1};
        vt[4] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 0};
        vt[5] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, 0};
        vt[6] = '{16'h9000, 1'b0, 1'b1, 16'h0010, 1};

        rst = 1'b0; start = 1'b0; cont = 1'b0; data_in = '0;
        hist = '0; hlen = 0; mcnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bit", bit_out, 1'b0);
        chk("rst_match", match, 1'b0);
        chk("rst_count", match_count, 5'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            scan(vt[k].data, vt[k].cont, vt[k].inj, m, cnt);
            chk($sformatf("vec%0d_mask", k), m, vt[k].mask);
            chk($sformatf("vec%0d_count", k), cnt, vt[k].count);
        end

        // Reset in SHIFT cycle 6, then cont=1 must still see a cleared detector.
        @(negedge clk);
        start = 1'b1; data_in = 16'h9000; cont = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_count", match_count, 5'd0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_bit", bit_out, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("mid_rst_quiet", {busy, done}, 2'b00);
        end
        hlen = 0;
        scan(16'h9000, 1'b1, 1'b0, m, cnt);
        chk("post_rst_mask", m, 16'h0010);
        chk("post_rst_count", cnt, 1);

        for (int r = 0; r < 30; r++) begin
            logic [15:0] d;
            d = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 2) == 0) d = d | 16'h9240;
            scan(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), m, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
